password_verifier: RTL



---
 rtl/pw_pkg.sv | 14 +
 rtl/password_verifier_if.sv | 24 ++
 rtl/password_verifier_lockout_timer.sv | 29 ++
 rtl/password_verifier.sv | 115 +++++++++++
 4 files changed

// File: rtl/pw_pkg.sv
// Shared types and constants for the password verifier and its lockout timer.
package pw_pkg;
  localparam int PW_WIDTH   = 16;
  localparam int ADDR_WIDTH = 16;
  localparam logic [PW_WIDTH-1:0] NO_ACCOUNT = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    LOCK  = 3'd4
  } state_t;
endpackage

// File: rtl/password_verifier_if.sv
// Request/response bundle between a requester (master) and the verifier (slave).
interface password_verifier_if;
  import pw_pkg::*;

  logic                  start;
  logic [ADDR_WIDTH-1:0] user_id;
  logic [PW_WIDTH-1:0]   pass_in;
  logic                  busy;
  logic                  done;
  logic                  grant;
  logic                  deny;
  logic                  locked;
  logic [3:0]            fail_count;

  modport master (
    output start, user_id, pass_in,
    input  busy, done, grant, deny, locked, fail_count
  );

  modport slave (
    input  start, user_id, pass_in,
    output busy, done, grant, deny, locked, fail_count
  );
endinterface

// File: rtl/password_verifier_lockout_timer.sv
// Loadable down-counter: active from load until the cycle it reads zero, when expire pulses.
module lockout_timer #(
  parameter int LOAD_VALUE = 999
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active,
  output logic expire
);
  localparam logic [15:0] LOAD_Q = 16'(LOAD_VALUE);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= LOAD_Q;
      active <= 1'b1;
    end else if (active) begin
      if (count == 16'd0) active <= 1'b0;
      else                count  <= count - 16'd1;
    end
  end

  assign expire = active && (count == 16'd0);
endmodule

// File: rtl/password_verifier.sv
// Looks up a user's stored password in a registered-read ROM, compares it with the
// entry, reports grant/deny and enforces a timed lockout after repeated failures.
module password_verifier
  import pw_pkg::*;
#(
  parameter int ROM_LATENCY    = 1,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  password_verifier_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [PW_WIDTH-1:0]   rom_data
);
  localparam logic [1:0] WAIT_LAST = 2'(ROM_LATENCY - 2);
  localparam logic [3:0] MAX_Q     = 4'(MAX_TRIES);

  state_t              state, next_state;
  logic [PW_WIDTH-1:0] pass_q;
  logic [1:0]          wait_cnt;
  logic [3:0]          fail_q;
  logic                done_q, grant_q, deny_q;
  logic                is_none, is_match, hits_max, timer_load, expire, timer_active;

  assign is_none  = (rom_data == NO_ACCOUNT);
  assign is_match = (rom_data == pass_q);
  assign hits_max = ((fail_q + 4'd1) == MAX_Q);

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) next_state = FETCH;
      FETCH: next_state = (ROM_LATENCY == 1) ? CMP : WAIT;
      WAIT:  if (wait_cnt == WAIT_LAST) next_state = CMP;
      CMP: begin
        if (!is_none && !is_match && hits_max) begin
          next_state = LOCK;
          timer_load = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      LOCK:    if (expire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      pass_q   <= '0;
      wait_cnt <= '0;
      fail_q   <= '0;
      done_q   <= 1'b0;
      grant_q  <= 1'b0;
      deny_q   <= 1'b0;
    end else begin
      state   <= next_state;
      done_q  <= 1'b0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rom_addr <= bus.user_id;
            pass_q   <= bus.pass_in;
          end
        end
        FETCH: wait_cnt <= '0;
        WAIT:  wait_cnt <= wait_cnt + 2'd1;
        CMP: begin
          done_q <= 1'b1;
          // Missing account is denied without counting against the user.
          if (is_none) begin
            deny_q <= 1'b1;
          end else if (is_match) begin
            grant_q <= 1'b1;
            fail_q  <= '0;
          end else begin
            deny_q <= 1'b1;
            if (fail_q < MAX_Q) fail_q <= fail_q + 4'd1;
          end
        end
        LOCK: begin
          if (bus.start) begin
            done_q <= 1'b1;
            deny_q <= 1'b1;
          end
          if (expire) fail_q <= '0;
        end
        default: ;
      endcase
    end
  end

  lockout_timer #(
    .LOAD_VALUE(LOCKOUT_CYCLES - 1)
  ) u_lockout_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .active (timer_active),
    .expire (expire)
  );

  assign bus.busy       = (state != IDLE);
  assign bus.locked     = (state == LOCK) && timer_active;
  assign bus.done       = done_q;
  assign bus.grant      = grant_q;
  assign bus.deny       = deny_q;
  assign bus.fail_count = fail_q;
endmodule
